bus_mem_ctrl: RTL and testbench
===============================

BUS_MEM_CTRL -- requirements
Module: bus_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bus, MAR and MDR width.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning RAM address width, with ADDR_W <= DATA_W.
REQ-003 SHALL have parameter RD_LAT, default 1, legal range 1..4, meaning the RAM read latency in clock edges.
REQ-004 SHALL provide port: clk, input, 1, the single clock; all state changes on rising edge.
REQ-005 SHALL provide port: reset, input, 1, synchronous, active-high.
REQ-006 SHALL provide port: bus_in, input, DATA_W, value currently on the processor bus.
REQ-007 SHALL provide port: bus_out, output, DATA_W, MDR contents; zero whenever bus_oe=0.
REQ-008 SHALL provide port: bus_oe, output, 1, bus drive enable; top level tristates on it.
REQ-009 SHALL provide port: MAR_in, input, 1, latch bus_in into MAR.
REQ-010 SHALL provide port: MDR_in, input, 1, latch bus_in into MDR.
REQ-011 SHALL provide port: MDR_out, input, 1, drive MDR onto bus.
REQ-012 SHALL provide port: rd_req, input, 1, start a RAM read at MAR.
REQ-013 SHALL provide port: wr_req, input, 1, start a RAM write of MDR at MAR.
REQ-014 SHALL provide port: busy, output, 1, an access is in progress.
REQ-015 SHALL provide port: done, output, 1, one-cycle access-complete pulse.
REQ-016 SHALL provide port: err, output, 1, sticky error flag.
REQ-017 SHALL provide port: ram_addr, output, ADDR_W, MAR[ADDR_W-1:0].
REQ-018 SHALL provide port: ram_wdata, output, DATA_W, MDR contents.
REQ-019 SHALL provide port: ram_rdata, input, DATA_W, RAM read data.
REQ-020 SHALL provide port: ram_we, output, 1, registered write strobe.
REQ-021 SHALL provide port: ram_re, output, 1, registered read strobe.

Function
REQ-022 SHALL implement FSM states IDLE, RD_WAIT, WR, DONE; busy=1 in RD_WAIT and WR only.
REQ-023 In IDLE, MAR_in=1 SHALL load MAR; MDR_in=1 SHALL load MDR; both may occur in the same edge.
REQ-024 Outside IDLE, MAR_in and MDR_in SHALL be ignored, so MAR and MDR stay stable during an access.
REQ-025 bus_oe SHALL equal MDR_out combinationally in every state, so reads of MDR are possible while busy.
REQ-026 An access request SHALL be accepted only in IDLE; requests in other states SHALL be dropped silently.
REQ-027 Read: if rd_req=1 and wr_req=0 at edge E0 in IDLE: RD_WAIT; ram_re=1 for exactly the cycle after E0; MDR <= ram_rdata at edge E(1+RD_LAT); DONE for the following cycle; then IDLE.
REQ-028 Write: if wr_req=1 and rd_req=0 at edge E0 in IDLE: WR with ram_we=1 for exactly one cycle; DONE next cycle; then IDLE.
REQ-029 done SHALL be 1 only in DONE (exactly one cycle per access); busy=0 in DONE.
REQ-030 A request coinciding with DONE SHALL be dropped; the earliest next acceptance is the edge leaving DONE (IDLE sampled).
REQ-031 rd_req=1 and wr_req=1 together in IDLE SHALL set err, start no access, and hold the FSM in IDLE.
REQ-032 An accepted request with MAR[DATA_W-1:ADDR_W] != 0 SHALL set err, assert no RAM strobe, and go directly to DONE.
REQ-033 err SHALL clear only on reset.
REQ-034 ram_we and ram_re SHALL never be high together, and each SHALL be high at most one cycle per access.
REQ-035 An RD_WAIT latency counter SHALL be ceil(log2(RD_LAT+1)) bits wide and SHALL not wrap.

Reset
REQ-036 Reset SHALL force: IDLE, MAR=0, MDR=0, err=0, busy=0, done=0, ram_we=0, ram_re=0, counter=0.
REQ-037 Reset mid-access SHALL abort the access: no later strobe, no MDR capture, no done pulse.
REQ-038 Reset SHALL take priority over all other inputs in the same edge.

Verification
REQ-039 RD_LAT=2, MAR_in with bus_in=0x0012, then rd_req, RAM[0x12]=0xBEEF -> ram_re one cycle at addr 0x12; MDR=0xBEEF after edge E3; done in cycle 4; busy in cycles 1-3.
REQ-040 MAR=0x0005, MDR_in with 0x1234, wr_req -> ram_we one cycle, ram_wdata=0x1234, ram_addr=0x05; done the next cycle; err=0.
REQ-041 rd_req=wr_req=1 in IDLE -> err=1, no strobes, busy stays 0; err persists until reset.
REQ-042 MAR=0x0100 (ADDR_W=8), rd_req -> no ram_re, err=1, done pulses one cycle later.
REQ-043 During RD_WAIT: MDR_in with 0xFFFF and a second rd_req -> MDR holds the read data, and exactly one done.
REQ-044 Reset asserted in the cycle after rd_req acceptance -> IDLE, MDR=0, no done, and no further ram_re.

Source files
------------

// File: rtl/bus_mem_ctrl.sv
// bus_mem_ctrl: MAR/MDR bus interface sequencing single-word reads and writes to a
// synchronous RAM with configurable read latency and a sticky error flag.
module bus_mem_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              MAR_in,
    input  logic              MDR_in,
    input  logic              MDR_out,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_we,
    output logic              ram_re
);
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mar, mdr;
    logic [CW-1:0]     cnt;
    logic              idle, bad_addr, single, conflict, rd_go, wr_go, bad_go, capture;

    always_comb begin
        idle      = state == IDLE;
        bad_addr  = |(mar >> ADDR_W);
        single    = rd_req ^ wr_req;
        conflict  = idle && rd_req && wr_req;
        rd_go     = idle && rd_req && !wr_req && !bad_addr;
        wr_go     = idle && wr_req && !rd_req && !bad_addr;
        bad_go    = idle && single && bad_addr;
        capture   = state == RD_WAIT && cnt == CW'(RD_LAT);
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = rd_go ? RD_WAIT : wr_go ? WR : bad_go ? DONE : IDLE;
            RD_WAIT: state_nxt = capture ? DONE : RD_WAIT;
            WR:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mar    <= '0;
            mdr    <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            ram_we <= 1'b0;
            ram_re <= 1'b0;
        end else begin
            state  <= state_nxt;
            ram_re <= rd_go;
            ram_we <= wr_go;
            err    <= err | conflict | bad_go;
            // counter saturates at RD_LAT: capture leaves RD_WAIT on that same edge
            cnt    <= (state == RD_WAIT && !capture) ? cnt + CW'(1) : '0;
            if (idle && MAR_in)
                mar <= bus_in;
            if (idle && MDR_in)
                mdr <= bus_in;
            else if (capture)
                mdr <= ram_rdata;
        end
    end

    assign busy      = state == RD_WAIT || state == WR;
    assign done      = state == DONE;
    assign bus_oe    = MDR_out;
    assign bus_out   = MDR_out ? mdr : '0;
    assign ram_addr  = mar[ADDR_W-1:0];
    assign ram_wdata = mdr;
endmodule

// File: tb/tb_bus_mem_ctrl.sv
// tb_bus_mem_ctrl: randomized transaction-level bench for bus_mem_ctrl with a
// latency-accurate RAM model and a register/memory reference model.
module tb_bus_mem_ctrl;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] bus_in, bus_out, ram_wdata, ram_rdata;
    logic          bus_oe, MAR_in, MDR_in, MDR_out, rd_req, wr_req;
    logic          busy, done, err, ram_we, ram_re;
    logic [AW-1:0] ram_addr;

    bus_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL)) dut (
        .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .MAR_in(MAR_in), .MDR_in(MDR_in), .MDR_out(MDR_out), .rd_req(rd_req), .wr_req(wr_req),
        .busy(busy), .done(done), .err(err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_we(ram_we), .ram_re(ram_re)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] seed(int i);
        return (i == 'h12) ? 16'hBEEF : DW'(i * 40503) ^ 16'h5A5A;
    endfunction

    // RAM environment: data appears RD_LAT edges after the read strobe is seen
    logic [DW-1:0] ram [256];
    logic [RL-1:0] pipe = '0;
    logic          ram_init = 1'b0;
    always @(posedge clk) begin
        if (ram_init)
            for (int i = 0; i < 256; i++) ram[i] <= seed(i);
        else if (ram_we)
            ram[ram_addr] <= ram_wdata;
        pipe <= {pipe[RL-2:0], ram_re};
    end
    assign ram_rdata = pipe[RL-1] ? ram[ram_addr] : 16'hDEAD;

    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] m_mar, m_mdr;
    logic          m_err;
    int            n_checks = 0, n_errors = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        MAR_in = 0; MDR_in = 0; MDR_out = 0; rd_req = 0; wr_req = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
        m_mar = '0; m_mdr = '0; m_err = 0;
    endtask

    task automatic load(logic [DW-1:0] v, bit ma, bit md);
        bus_in = v; MAR_in = ma; MDR_in = md;
        step();
        idle_in();
        if (ma) m_mar = v;
        if (md) m_mdr = v;
    endtask

    task automatic check_idle(string tag);
        MDR_out = 1;
        @(negedge clk);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".re"}, ram_re, 0);
        chk({tag, ".we"}, ram_we, 0);
        chk({tag, ".err"}, err, m_err);
        chk({tag, ".oe"}, bus_oe, 1);
        chk({tag, ".mdr"}, bus_out, m_mdr);
        step();
        MDR_out = 0;
    endtask

    task automatic access(bit rd, bit wr, bit junk);
        bit            bad = (m_mar >> AW) != 0;
        logic [DW-1:0] old = m_mdr, exp_mdr;
        logic [AW-1:0] a = m_mar[AW-1:0];
        int            len = bad ? 1 : rd ? RL + 2 : 2;
        rd_req = rd; wr_req = wr;
        step();
        idle_in();
        if (rd && wr) begin
            m_err = 1;
            @(negedge clk);
            chk("conf.busy", busy, 0);
            chk("conf.done", done, 0);
            chk("conf.strobe", {ram_re, ram_we}, 0);
            chk("conf.err", err, 1);
            step();
            return;
        end
        if (bad) m_err = 1;
        for (int k = 1; k <= len; k++) begin
            if (junk) begin
                bus_in = DW'($urandom); MAR_in = 1'($urandom); MDR_in = 1'($urandom);
                rd_req = 1'($urandom); wr_req = 1'($urandom); MDR_out = 1'($urandom);
            end
            @(negedge clk);
            exp_mdr = (rd && !bad && k == len) ? ref_mem[a] : old;
            chk("acc.busy", busy, k < len);
            chk("acc.done", done, k == len);
            chk("acc.re", ram_re, rd && !bad && k == 1);
            chk("acc.we", ram_we, wr && !bad && k == 1);
            chk("acc.err", err, m_err);
            chk("acc.bus", bus_out, MDR_out ? exp_mdr : '0);
            if (!bad && k == 1) chk("acc.addr", ram_addr, a);
            if (wr && !bad && k == 1) chk("acc.wdata", ram_wdata, old);
            step();
        end
        idle_in();
        if (rd && !bad) m_mdr = ref_mem[a];
        if (wr && !bad) ref_mem[a] = old;
    endtask

    task automatic reset_mid_read();
        load(16'h0033, 1, 0);
        rd_req = 1;
        step();
        idle_in();
        do_reset();
        for (int k = 0; k < RL + 3; k++) begin
            MDR_out = 1;
            @(negedge clk);
            chk("rst.busy", busy, 0);
            chk("rst.done", done, 0);
            chk("rst.re", ram_re, 0);
            chk("rst.mdr", bus_out, 0);
            step();
        end
        idle_in();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        idle_in();
        bus_in = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
        ram_init = 1;
        do_reset();
        ram_init = 0;
        do_reset();
        check_idle("reset");
        load(16'h0012, 1, 0);
        access(1, 0, 0);
        check_idle("rd12");
        load(16'h0005, 1, 0);
        load(16'h1234, 0, 1);
        access(0, 1, 0);
        check_idle("wr05");
        load(16'h0005, 1, 0);
        access(1, 0, 1);
        check_idle("rdjunk");
        reset_mid_read();
        check_idle("postrst");
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0: load(($urandom_range(0, 7) == 0) ? (DW'($urandom) | 16'h0100)
                                                     : DW'($urandom_range(0, 255)), 1, 0);
                1: load(DW'($urandom), 0, 1);
                2: load(DW'($urandom_range(0, 255)), 1, 1);
                3: access(1, 0, 1'($urandom));
                4: access(0, 1, 1'($urandom));
                default: if ($urandom_range(0, 9) == 0) access(1, 1, 0); else check_idle("rand");
            endcase
        end
        do_reset();
        access(1, 1, 0);
        check_idle("conf1");
        check_idle("conf2");
        do_reset();
        load(16'h0100, 1, 0);
        access(1, 0, 0);
        check_idle("bad");
        do_reset();
        check_idle("clr");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
